// File: rtl/burst_request_arbiter.sv
// Round-robin arbiter with a bounded consecutive-grant run. It feeds one burst issuer
// from NumPorts requesters, pushing address, burst length and id together.
module burst_request_arbiter #(
  parameter int NumPorts       = 4,
  parameter int AddrWidth      = 64,
  parameter int BurstLenWidth  = 8,
  parameter int IdWidth        = 2,
  parameter int MaxConsecutive = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumPorts*AddrWidth-1:0]     req_addr_dout,
  input  logic [NumPorts*BurstLenWidth-1:0] req_len_dout,
  input  logic [NumPorts-1:0]               req_empty_n,
  output logic [NumPorts-1:0]               req_read,
  output logic [AddrWidth-1:0]              addr_din,
  input  logic                              addr_full_n,
  output logic                              addr_write,
  output logic [BurstLenWidth-1:0]          burst_len_din,
  input  logic                              burst_len_full_n,
  output logic                              burst_len_write,
  output logic [IdWidth-1:0]                id_din,
  input  logic                              id_full_n,
  output logic                              id_write
);

  localparam int                  RunWidth = $clog2(MaxConsecutive + 1);
  localparam logic [RunWidth-1:0] RunMax   = RunWidth'(MaxConsecutive);
  localparam logic [RunWidth-1:0] RunOne   = RunWidth'(1);
  localparam logic [IdWidth:0]    PortsW   = (IdWidth + 1)'(NumPorts);
  localparam logic [IdWidth-1:0]  LastPort = IdWidth'(NumPorts - 1);

  logic [IdWidth-1:0]  last_grant_q, last_grant_d;
  logic [IdWidth-1:0]  owner_q, owner_d;
  logic [RunWidth-1:0] run_q, run_d;

  logic [IdWidth-1:0]  scan_cand [NumPorts];
  logic [NumPorts-1:0] scan_hit;
  logic [IdWidth-1:0]  scan_sel;
  logic                scan_valid;
  logic                sticky;
  logic [IdWidth-1:0]  sel;
  logic                sel_valid;
  logic                out_ready;
  logic                fire;
  logic [NumPorts-1:0] grant_oh;

  // Candidate gi is the port at distance gi+1 after last_grant; the sum stays below
  // 2*NumPorts, so one conditional subtract is an exact modulo for any port count.
  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_scan
      logic [IdWidth:0] sum;
      assign sum           = {1'b0, last_grant_q} + (IdWidth + 1)'(gi + 1);
      assign scan_cand[gi] = (sum >= PortsW) ? IdWidth'(sum - PortsW) : sum[IdWidth-1:0];
      assign scan_hit[gi]  = req_empty_n[scan_cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest hit is the one kept.
  always_comb begin
    scan_valid = 1'b0;
    scan_sel   = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (scan_hit[k]) begin
        scan_valid = 1'b1;
        scan_sel   = scan_cand[k];
      end
    end
  end

  assign sticky    = (run_q != '0) && (run_q < RunMax) && req_empty_n[owner_q];
  assign sel       = sticky ? owner_q : scan_sel;
  assign sel_valid = sticky | scan_valid;
  assign out_ready = addr_full_n & burst_len_full_n & id_full_n;
  assign fire      = sel_valid & out_ready & ~rst;

  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_grant
      assign grant_oh[gi] = fire && (sel == IdWidth'(gi));
    end
  endgenerate

  always_comb begin
    addr_din      = '0;
    burst_len_din = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (grant_oh[i]) begin
        addr_din      = addr_din | req_addr_dout[i*AddrWidth +: AddrWidth];
        burst_len_din = burst_len_din | req_len_dout[i*BurstLenWidth +: BurstLenWidth];
      end
    end
  end

  assign req_read        = grant_oh;
  assign addr_write      = fire;
  assign burst_len_write = fire;
  assign id_write        = fire;
  assign id_din          = fire ? sel : '0;

  // A grant reached through the scan (including an expired owner re-won) restarts the run.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    run_d        = run_q;
    if (fire) begin
      last_grant_d = sel;
      if (sticky) begin
        run_d = (run_q >= RunMax) ? RunMax : run_q + RunOne;
      end else begin
        owner_d = sel;
        run_d   = RunOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LastPort;
      owner_q      <= '0;
      run_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      run_q        <= run_d;
    end
  end

endmodule

// File: tb/tb_burst_request_arbiter.sv
// Bench for burst_request_arbiter: queue-based requester model with a rule-level
// arbitration model, plus fixed-traffic instances for the short-run configurations.
module tb_burst_request_arbiter;

  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int LW   = 8;
  localparam int IW   = 2;
  localparam int MAXA = 4;
  localparam logic [63:0] BASE_BC = 64'hB000_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: MaxConsecutive=4, model-checked
  logic            rst_a;
  logic [N*AW-1:0] addr_a;
  logic [N*LW-1:0] len_a;
  logic [N-1:0]    ne_a, rd_a;
  logic [AW-1:0]   ad_a;
  logic            af_a, aw_a, lf_a, lw_a, idf_a, idw_a;
  logic [LW-1:0]   ld_a;
  logic [IW-1:0]   id_a;

  // instances b (MaxConsecutive=2) and c (MaxConsecutive=1): constant requesters
  logic            rst_bc;
  logic [N*AW-1:0] addr_bc;
  logic [N*LW-1:0] len_bc;
  logic [N-1:0]    ne_b, rd_b, ne_c, rd_c;
  logic [AW-1:0]   ad_b, ad_c;
  logic            af_b, aw_b, lf_b, lw_b, idf_b, idw_b;
  logic            af_c, aw_c, lf_c, lw_c, idf_c, idw_c;
  logic [LW-1:0]   ld_b, ld_c;
  logic [IW-1:0]   id_b, id_c;

  burst_request_arbiter #(.NumPorts(N), .AddrWidth(AW), .BurstLenWidth(LW),
                          .IdWidth(IW), .MaxConsecutive(MAXA)) dut_a (
    .clk(clk), .rst(rst_a), .req_addr_dout(addr_a), .req_len_dout(len_a),
    .req_empty_n(ne_a), .req_read(rd_a), .addr_din(ad_a), .addr_full_n(af_a),
    .addr_write(aw_a), .burst_len_din(ld_a), .burst_len_full_n(lf_a),
    .burst_len_write(lw_a), .id_din(id_a), .id_full_n(idf_a), .id_write(idw_a));

  burst_request_arbiter #(.NumPorts(N), .AddrWidth(AW), .BurstLenWidth(LW),
                          .IdWidth(IW), .MaxConsecutive(2)) dut_b (
    .clk(clk), .rst(rst_bc), .req_addr_dout(addr_bc), .req_len_dout(len_bc),
    .req_empty_n(ne_b), .req_read(rd_b), .addr_din(ad_b), .addr_full_n(af_b),
    .addr_write(aw_b), .burst_len_din(ld_b), .burst_len_full_n(lf_b),
    .burst_len_write(lw_b), .id_din(id_b), .id_full_n(idf_b), .id_write(idw_b));

  burst_request_arbiter #(.NumPorts(N), .AddrWidth(AW), .BurstLenWidth(LW),
                          .IdWidth(IW), .MaxConsecutive(1)) dut_c (
    .clk(clk), .rst(rst_bc), .req_addr_dout(addr_bc), .req_len_dout(len_bc),
    .req_empty_n(ne_c), .req_read(rd_c), .addr_din(ad_c), .addr_full_n(af_c),
    .addr_write(aw_c), .burst_len_din(ld_c), .burst_len_full_n(lf_c),
    .burst_len_write(lw_c), .id_din(id_c), .id_full_n(idf_c), .id_write(idw_c));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // controls applied at the next falling edge
  logic       n_rst_a, n_rst_bc;
  logic [2:0] n_full_a, n_full_b, n_full_c;

  // per-port request FIFOs seen by instance a
  logic [63:0] q_addr [N][256];
  logic [7:0]  q_len  [N][256];
  int          hd [N];
  int          tl [N];

  // reference state: who was granted last, who holds the run, how long it is
  int m_last, m_owner, m_run;

  // grants observed on the DUT outputs
  int          log_id  [$];
  int          log_len [$];
  logic [63:0] log_adr [$];
  int          log_cyc [$];
  int          log_b   [$];
  int          log_c   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_req(input int p, input logic [63:0] a, input logic [7:0] l);
    if (tl[p] - hd[p] < 200) begin
      q_addr[p][tl[p] % 256] = a;
      q_len[p][tl[p] % 256]  = l;
      tl[p]++;
    end
  endtask

  task automatic step();
    int          sel;
    bit          stk, fire;
    bit          nev [N];
    logic [N-1:0] e_rd;
    logic [63:0] e_ad;
    logic [7:0]  e_len;
    @(negedge clk);
    rst_a  = n_rst_a;
    rst_bc = n_rst_bc;
    {af_a, lf_a, idf_a} = n_full_a;
    {af_b, lf_b, idf_b} = n_full_b;
    {af_c, lf_c, idf_c} = n_full_c;
    for (int p = 0; p < N; p++) begin
      nev[p] = (tl[p] != hd[p]);
      ne_a[p] = nev[p];
      if (nev[p]) begin
        addr_a[p*AW +: AW] = q_addr[p][hd[p] % 256];
        len_a[p*LW +: LW]  = q_len[p][hd[p] % 256];
      end else begin
        addr_a[p*AW +: AW] = {$urandom(), $urandom()};
        len_a[p*LW +: LW]  = 8'($urandom());
      end
    end
    #1;
    // arbitration rules: keep the owner while its run is short, else next nonempty after last
    sel  = -1;
    stk  = 1'b0;
    fire = 1'b0;
    if (!rst_a) begin
      stk = (m_run != 0) && (m_run < MAXA) && nev[m_owner];
      if (stk) sel = m_owner;
      else
        for (int k = 1; k <= N; k++)
          if (sel < 0 && nev[(m_last + k) % N]) sel = (m_last + k) % N;
      fire = (sel >= 0) && af_a && lf_a && idf_a;
    end
    e_rd  = '0;
    e_ad  = '0;
    e_len = '0;
    if (fire) begin
      e_rd[sel] = 1'b1;
      e_ad      = q_addr[sel][hd[sel] % 256];
      e_len     = q_len[sel][hd[sel] % 256];
    end
    check("a_req_read", 64'(rd_a), 64'(e_rd));
    check("a_addr_write", 64'(aw_a), 64'(fire));
    check("a_len_write", 64'(lw_a), 64'(fire));
    check("a_id_write", 64'(idw_a), 64'(fire));
    check("a_addr_din", ad_a, e_ad);
    check("a_len_din", 64'(ld_a), 64'(e_len));
    check("a_id_din", 64'(id_a), fire ? 64'(sel) : 64'd0);
    if (aw_a) begin
      log_id.push_back(int'(id_a));
      log_len.push_back(int'(ld_a));
      log_adr.push_back(ad_a);
      log_cyc.push_back(cyc);
      $display("[%0d] a grant id=%0d len=%0d addr=%h", cyc, id_a, ld_a, ad_a);
    end
    if (rst_a) begin
      m_last  = N - 1;
      m_owner = 0;
      m_run   = 0;
    end else if (fire) begin
      hd[sel]++;
      if (stk) m_run = (m_run + 1 > MAXA) ? MAXA : m_run + 1;
      else begin
        m_owner = sel;
        m_run   = 1;
      end
      m_last = sel;
    end
    if (!rst_bc && idw_b) begin
      log_b.push_back(int'(id_b));
      check("b_addr_din", ad_b, BASE_BC + 64'(id_b));
      check("b_req_read", 64'(rd_b), 64'(1) << id_b);
      $display("[%0d] b grant id=%0d", cyc, id_b);
    end
    if (!rst_bc && !idf_b)
      check("b_stall_quiet", {60'd0, rd_b | {aw_b, lw_b, idw_b, 1'b0}}, 64'd0);
    if (!rst_bc && idw_c) begin
      log_c.push_back(int'(id_c));
      $display("[%0d] c grant id=%0d", cyc, id_c);
    end
    check("c_ports_0_2_idle", {62'd0, rd_c[2], rd_c[0]}, 64'd0);
    cyc++;
  endtask

  int base;
  int rate [N];
  int t2_exp [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
  int t4_exp [8]  = '{1, 2, 2, 2, 2, 1, 2, 2};
  int t6_exp [5]  = '{0, 0, 0, 0, 1};
  int t5_exp [4]  = '{1, 3, 1, 3};
  int t1_len [3]  = '{0, 3, 255};

  initial begin
    for (int p = 0; p < N; p++) begin
      hd[p] = 0;
      tl[p] = 0;
      addr_bc[p*AW +: AW] = BASE_BC + 64'(p);
      len_bc[p*LW +: LW]  = 8'(p + 16);
    end
    ne_b = 4'b1111;
    ne_c = 4'b1010;
    addr_a = '0; len_a = '0; ne_a = '0;
    rst_a = 1'b1; rst_bc = 1'b1;
    {af_a, lf_a, idf_a} = 3'b111;
    {af_b, lf_b, idf_b} = 3'b111;
    {af_c, lf_c, idf_c} = 3'b111;
    n_rst_a = 1'b1; n_rst_bc = 1'b1;
    n_full_a = 3'b111; n_full_b = 3'b111; n_full_c = 3'b111;
    m_last = N - 1; m_owner = 0; m_run = 0;
    step();
    step();
    check("reset_no_grant", 64'(log_id.size()), 64'd0);

    // T1 on a, T2/T3 on b, T5 on c, all in the same cycles
    push_req(0, 64'h1000_0000_0000_0000, 8'd0);
    push_req(0, 64'h1000_0000_0000_0040, 8'd3);
    push_req(0, 64'h1000_0000_0000_0080, 8'd255);
    n_rst_a = 1'b0;
    n_rst_bc = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n_full_b = (i >= 9 && i < 14) ? 3'b110 : 3'b111;
      step();
    end
    n_full_b = 3'b111;

    check("t1_count", 64'(log_id.size()), 64'd3);
    if (log_id.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        check("t1_id", 64'(log_id[i]), 64'd0);
        check("t1_len", 64'(log_len[i]), 64'(t1_len[i]));
        check("t1_addr", log_adr[i], 64'h1000_0000_0000_0000 + 64'(i * 64));
        if (i > 0) check("t1_back_to_back", 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
      end
    check("t2t3_count", 64'(log_b.size()), 64'd12);
    if (log_b.size() >= 12)
      for (int i = 0; i < 12; i++) check("t2t3_id", 64'(log_b[i]), 64'(t2_exp[i]));
    check("t5_count_min", 64'(log_c.size() >= 4), 64'd1);
    if (log_c.size() >= 4)
      for (int i = 0; i < 4; i++) check("t5_id", 64'(log_c[i]), 64'(t5_exp[i]));

    // T4: port 1 single, port 2 six deep, port 1 refilled while port 2 runs
    base = log_id.size();
    push_req(1, 64'h2100_0000_0000_0000, 8'd7);
    for (int i = 0; i < 6; i++) push_req(2, 64'h2200_0000_0000_0000 + 64'(i), 8'(i));
    for (int i = 0; i < 3; i++) step();
    push_req(1, 64'h2100_0000_0000_0001, 8'd9);
    for (int i = 0; i < 9; i++) step();
    check("t4_count", 64'(log_id.size() - base), 64'd8);
    if (log_id.size() >= base + 8)
      for (int i = 0; i < 8; i++) check("t4_id", 64'(log_id[base+i]), 64'(t4_exp[i]));

    // T6: reset in the middle of a port-2 run with every port loaded
    base = log_id.size();
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 8; i++) push_req(p, {8'(p), 56'(i)}, 8'(p * 8 + i));
    step();
    n_rst_a = 1'b1;
    step();
    n_rst_a = 1'b0;
    check("t6_rst_quiet", 64'(log_id.size() - base), 64'd1);
    for (int i = 0; i < 5; i++) step();
    check("t6_count", 64'(log_id.size() - base), 64'd6);
    if (log_id.size() >= base + 6) begin
      check("t6_pre_id", 64'(log_id[base]), 64'd2);
      for (int i = 0; i < 5; i++) check("t6_id", 64'(log_id[base+1+i]), 64'(t6_exp[i]));
    end

    // randomized traffic, back-pressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0)
        for (int p = 0; p < N; p++) rate[p] = $urandom_range(0, 70);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 99) < rate[p])
          push_req(p, {$urandom(), $urandom()}, 8'($urandom()));
      n_full_a = {$urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 85};
      n_rst_a = ($urandom_range(0, 599) == 0);
      step();
    end
    n_rst_a = 1'b0;
    n_full_a = 3'b111;
    for (int i = 0; i < 40; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
